dual_port_bram_memory_subsystem: RTL and testbench

Byte-lane, dual-port block-RAM main memory for the skivav RISC-V core. Port I serves instruction fetch (read-only); port D serves loads and stores with per-byte write enables. Both ports share one storage image organised as DATA_WIDTH/8 byte-wide lanes, so benches can back-door load and inspect contents. Sits beside the core, between its fetch/memory stages and the rest of the system.

---
 rtl/dual_port_bram_memory_subsystem.sv | 203 ++++++++++++++++++++
 tb/tb_dual_port_bram_memory_subsystem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_bram_memory_subsystem.sv
// Dual-port byte-lane block-RAM main memory: port I fetches, port D loads/stores with byte enables.
// Optional debug request trace is built only when MEM_SCAN_EN is defined.

module bram_byte_lane #(
    parameter int MEM_ADDRESS_BITS = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_rd_en,
    input  logic [MEM_ADDRESS_BITS-1:0] i_idx,
    output logic [7:0]                  i_rd_data,
    input  logic                        d_rd_en,
    input  logic                        d_wr_en,
    input  logic [MEM_ADDRESS_BITS-1:0] d_idx,
    input  logic [7:0]                  d_wr_data,
    output logic [7:0]                  d_rd_data
);
    localparam int DEPTH = 2 ** MEM_ADDRESS_BITS;

    // ram mirrors every port-D write so the fetch path sees stores one cycle later.
    logic [7:0] ram      [DEPTH];
    logic [7:0] ram_data [DEPTH];
    logic [7:0] i_rd_q;
    logic [7:0] d_rd_q;

    always_ff @(posedge clock) begin
        if (d_wr_en) begin
            ram[d_idx]      <= d_wr_data;
            ram_data[d_idx] <= d_wr_data;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_rd_q <= 8'h00;
            d_rd_q <= 8'h00;
        end else begin
            if (i_rd_en) begin
                i_rd_q <= ram[i_idx];
            end
            if (d_rd_en) begin
                d_rd_q <= ram_data[d_idx];
            end
        end
    end

    assign i_rd_data = i_rd_q;
    assign d_rd_data = d_rd_q;
endmodule

module bram_memory #(
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_ADDRESS_BITS = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_rd_en,
    input  logic [MEM_ADDRESS_BITS-1:0] i_idx,
    output logic [DATA_WIDTH-1:0]       i_rd_data,
    input  logic                        d_rd_en,
    input  logic                        d_wr_en,
    input  logic [DATA_WIDTH/8-1:0]     d_byte_en,
    input  logic [MEM_ADDRESS_BITS-1:0] d_idx,
    input  logic [DATA_WIDTH-1:0]       d_wr_data,
    output logic [DATA_WIDTH-1:0]       d_rd_data
);
    localparam int LANES = DATA_WIDTH / 8;

    for (genvar gi = 0; gi < LANES; gi++) begin : BYTE_LOOP
        bram_byte_lane #(
            .MEM_ADDRESS_BITS(MEM_ADDRESS_BITS)
        ) BRAM_byte (
            .clock    (clock),
            .reset    (reset),
            .i_rd_en  (i_rd_en),
            .i_idx    (i_idx),
            .i_rd_data(i_rd_data[8*gi +: 8]),
            .d_rd_en  (d_rd_en),
            .d_wr_en  (d_wr_en & d_byte_en[gi]),
            .d_idx    (d_idx),
            .d_wr_data(d_wr_data[8*gi +: 8]),
            .d_rd_data(d_rd_data[8*gi +: 8])
        );
    end
endmodule

module dual_port_bram_memory_subsystem #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDRESS_BITS     = 32,
    parameter int MEM_ADDRESS_BITS = 20,
    parameter int SCAN_CYCLES_MIN  = 0,
    parameter int SCAN_CYCLES_MAX  = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_mem_read,
    input  logic [ADDRESS_BITS-1:0]   i_mem_address_in,
    output logic [DATA_WIDTH-1:0]     i_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   i_mem_address_out,
    output logic                      i_mem_valid,
    output logic                      i_mem_ready,
    input  logic                      d_mem_read,
    input  logic                      d_mem_write,
    input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
    input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
    input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
    output logic [DATA_WIDTH-1:0]     d_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
    output logic                      d_mem_valid,
    output logic                      d_mem_ready,
    input  logic                      scan
);
    logic [MEM_ADDRESS_BITS-1:0] i_idx;
    logic [MEM_ADDRESS_BITS-1:0] d_idx;
    logic [ADDRESS_BITS-1:0]     i_addr_q;
    logic [ADDRESS_BITS-1:0]     d_addr_q;
    logic                        i_valid_q;
    logic                        d_valid_q;
    logic                        ready_q;

    // Byte offset and bits above the index are dropped, so addresses wrap modulo depth.
    assign i_idx = i_mem_address_in[MEM_ADDRESS_BITS+1:2];
    assign d_idx = d_mem_address_in[MEM_ADDRESS_BITS+1:2];

    bram_memory #(
        .DATA_WIDTH      (DATA_WIDTH),
        .MEM_ADDRESS_BITS(MEM_ADDRESS_BITS)
    ) memory (
        .clock    (clock),
        .reset    (reset),
        .i_rd_en  (i_mem_read),
        .i_idx    (i_idx),
        .i_rd_data(i_mem_data_out),
        .d_rd_en  (d_mem_read),
        .d_wr_en  (d_mem_write),
        .d_byte_en(d_mem_byte_en),
        .d_idx    (d_idx),
        .d_wr_data(d_mem_data_in),
        .d_rd_data(d_mem_data_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            i_valid_q <= i_mem_read;
            d_valid_q <= d_mem_read;
            if (i_mem_read) begin
                i_addr_q <= i_mem_address_in;
            end
            if (d_mem_read) begin
                d_addr_q <= d_mem_address_in;
            end
        end
    end

    assign i_mem_address_out = i_addr_q;
    assign d_mem_address_out = d_addr_q;
    assign i_mem_valid       = i_valid_q;
    assign d_mem_valid       = d_valid_q;
    assign i_mem_ready       = ready_q;
    assign d_mem_ready       = ready_q;

`ifdef MEM_SCAN_EN
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;
    logic        in_window;

    assign cycle_d   = cycle_q + 32'd1;
    assign in_window = ($signed(cycle_q) >= SCAN_CYCLES_MIN) &&
                       ($signed(cycle_q) <= SCAN_CYCLES_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            if (scan && in_window) begin
                if (i_mem_read) begin
                    $display("[mem] cycle=%0d port=I addr=%h", cycle_q, i_mem_address_in);
                end
                if (d_mem_read || d_mem_write) begin
                    $display("[mem] cycle=%0d port=D rd=%0b wr=%0b addr=%h data=%h byte_en=%b",
                             cycle_q, d_mem_read, d_mem_write, d_mem_address_in,
                             d_mem_data_in, d_mem_byte_en);
                end
            end
        end
    end
`endif

    // Trace controls and untranslated address bits are intentionally unused in the default build.
    logic [31:0] unused_scan_span;
    logic        unused_ok;
    assign unused_scan_span = 32'(SCAN_CYCLES_MAX - SCAN_CYCLES_MIN);
    assign unused_ok        = ^{scan, i_mem_address_in, d_mem_address_in, unused_scan_span};
endmodule

// File: tb/tb_dual_port_bram_memory_subsystem.sv
// Randomised plus directed bench for dual_port_bram_memory_subsystem against a word-array model.
module tb_dual_port_bram_memory_subsystem;
    localparam int DW    = 32;
    localparam int AB    = 32;
    localparam int MAB   = 8;
    localparam int DEPTH = 2 ** MAB;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_mem_read = 1'b0;
    logic [AB-1:0] i_mem_address_in = '0;
    logic [DW-1:0] i_mem_data_out;
    logic [AB-1:0] i_mem_address_out;
    logic          i_mem_valid;
    logic          i_mem_ready;
    logic          d_mem_read = 1'b0;
    logic          d_mem_write = 1'b0;
    logic [3:0]    d_mem_byte_en = '0;
    logic [AB-1:0] d_mem_address_in = '0;
    logic [DW-1:0] d_mem_data_in = '0;
    logic [DW-1:0] d_mem_data_out;
    logic [AB-1:0] d_mem_address_out;
    logic          d_mem_valid;
    logic          d_mem_ready;
    logic          scan = 1'b0;

    dual_port_bram_memory_subsystem #(
        .DATA_WIDTH      (DW),
        .ADDRESS_BITS    (AB),
        .MEM_ADDRESS_BITS(MAB),
        .SCAN_CYCLES_MIN (0),
        .SCAN_CYCLES_MAX (10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .i_mem_read       (i_mem_read),
        .i_mem_address_in (i_mem_address_in),
        .i_mem_data_out   (i_mem_data_out),
        .i_mem_address_out(i_mem_address_out),
        .i_mem_valid      (i_mem_valid),
        .i_mem_ready      (i_mem_ready),
        .d_mem_read       (d_mem_read),
        .d_mem_write      (d_mem_write),
        .d_mem_byte_en    (d_mem_byte_en),
        .d_mem_address_in (d_mem_address_in),
        .d_mem_data_in    (d_mem_data_in),
        .d_mem_data_out   (d_mem_data_out),
        .d_mem_address_out(d_mem_address_out),
        .d_mem_valid      (d_mem_valid),
        .d_mem_ready      (d_mem_ready),
        .scan             (scan)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] ei_data = '0, ei_addr = '0, ed_data = '0, ed_addr = '0;
    logic        ei_valid = 1'b0, ed_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[MAB+1:2]);
    endfunction

    function automatic logic [31:0] bd_ram_data(input int idx);
        return {dut.memory.BYTE_LOOP[3].BRAM_byte.ram_data[idx],
                dut.memory.BYTE_LOOP[2].BRAM_byte.ram_data[idx],
                dut.memory.BYTE_LOOP[1].BRAM_byte.ram_data[idx],
                dut.memory.BYTE_LOOP[0].BRAM_byte.ram_data[idx]};
    endfunction

    function automatic logic [31:0] bd_ram(input int idx);
        return {dut.memory.BYTE_LOOP[3].BRAM_byte.ram[idx],
                dut.memory.BYTE_LOOP[2].BRAM_byte.ram[idx],
                dut.memory.BYTE_LOOP[1].BRAM_byte.ram[idx],
                dut.memory.BYTE_LOOP[0].BRAM_byte.ram[idx]};
    endfunction

    // One clock of traffic: expectations come from the model before the write lands (read-first).
    task automatic cycle(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [3:0] be,
                         input logic [31:0] da, input logic [31:0] dd);
        i_mem_read       = ir;
        i_mem_address_in = ia;
        d_mem_read       = dr;
        d_mem_write      = dw;
        d_mem_byte_en    = be;
        d_mem_address_in = da;
        d_mem_data_in    = dd;
        ei_valid = ir;
        ed_valid = dr;
        if (ir) begin
            ei_data = model[widx(ia)];
            ei_addr = ia;
        end
        if (dr) begin
            ed_data = model[widx(da)];
            ed_addr = da;
        end
        if (dw) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[widx(da)][8*b +: 8] = dd[8*b +: 8];
            end
        end
        @(posedge clock);
        #1;
        $display("txn t=%0t ir=%0b ia=%h dr=%0b dw=%0b be=%b da=%h dd=%h | i=%h/%h/%0b d=%h/%h/%0b",
                 $time, ir, ia, dr, dw, be, da, dd, i_mem_data_out, i_mem_address_out,
                 i_mem_valid, d_mem_data_out, d_mem_address_out, d_mem_valid);
        check("i_valid", {31'b0, i_mem_valid}, {31'b0, ei_valid});
        check("i_data", i_mem_data_out, ei_data);
        check("i_addr", i_mem_address_out, ei_addr);
        check("d_valid", {31'b0, d_mem_valid}, {31'b0, ed_valid});
        check("d_data", d_mem_data_out, ed_data);
        check("d_addr", d_mem_address_out, ed_addr);
        check("ready", {30'b0, i_mem_ready, d_mem_ready}, 32'd3);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_i_valid"}, {31'b0, i_mem_valid}, 32'd0);
        check({tag, "_d_valid"}, {31'b0, d_mem_valid}, 32'd0);
        check({tag, "_readies"}, {30'b0, i_mem_ready, d_mem_ready}, 32'd0);
        check({tag, "_i_data"}, i_mem_data_out, 32'd0);
        check({tag, "_d_data"}, d_mem_data_out, 32'd0);
        check({tag, "_i_addr"}, i_mem_address_out, 32'd0);
        check({tag, "_d_addr"}, d_mem_address_out, 32'd0);
    endtask

    initial begin
        // Reset with requests pending: everything stays 0.
        i_mem_read = 1'b1;
        d_mem_read = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_outputs_zero("rst");
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        reset = 1'b1;
        #1;
        check("ready_before_edge", {30'b0, i_mem_ready, d_mem_ready}, 32'd0);
        cycle(0, 0, 0, 0, 4'h0, 0, 0);

        // Fill every word through port D so contents are defined.
        for (int w = 0; w < DEPTH; w++) begin
            cycle(0, 0, 0, 1, 4'hF, 32'(w * 4), $urandom);
        end

        // Word 2 load and read back.
        cycle(0, 0, 0, 1, 4'hF, 32'h8, 32'h2B7E1516);
        cycle(0, 0, 1, 0, 4'h0, 32'h8, 0);
        check("w2_data", d_mem_data_out, 32'h2B7E1516);
        check("w2_addr", d_mem_address_out, 32'h8);
        check("w2_valid", {31'b0, d_mem_valid}, 32'd1);
        check("w2_backdoor", bd_ram_data(2), 32'h2B7E1516);

        // Partial byte write over 0x11223344.
        cycle(0, 0, 0, 1, 4'hF, 32'h28, 32'h11223344);
        cycle(0, 0, 0, 1, 4'b0101, 32'h28, 32'hAABBCCDD);
        cycle(1, 32'h28, 1, 0, 4'h0, 32'h28, 0);
        check("be_d_data", d_mem_data_out, 32'h11BB33DD);
        check("be_i_data", i_mem_data_out, 32'h11BB33DD);
        check("be_ram_image", bd_ram(10), 32'h11BB33DD);

        // Zero byte enable write leaves the word alone.
        cycle(0, 0, 0, 1, 4'h0, 32'h28, 32'hFFFFFFFF);
        cycle(0, 0, 1, 0, 4'h0, 32'h28, 0);
        check("be0_noop", d_mem_data_out, 32'h11BB33DD);

        // Consecutive fetches.
        cycle(1, 32'h0, 0, 0, 4'h0, 0, 0);
        check("fetch0_addr", i_mem_address_out, 32'h0);
        cycle(1, 32'h4, 0, 0, 4'h0, 0, 0);
        check("fetch1_addr", i_mem_address_out, 32'h4);
        cycle(1, 32'h8, 0, 0, 4'h0, 0, 0);
        check("fetch2_data", i_mem_data_out, 32'h2B7E1516);

        // Same-cycle write and read on 0x40 (both ports) returns the old word.
        cycle(0, 0, 0, 1, 4'hF, 32'h40, 32'h0);
        cycle(1, 32'h40, 1, 1, 4'hF, 32'h40, 32'hDEADBEEF);
        check("rf_d_old", d_mem_data_out, 32'h0);
        check("rf_i_old", i_mem_data_out, 32'h0);
        cycle(1, 32'h40, 1, 0, 4'h0, 32'h40, 0);
        check("rf_d_new", d_mem_data_out, 32'hDEADBEEF);
        check("rf_i_new", i_mem_data_out, 32'hDEADBEEF);

        // Idle cycle: valids drop, data and address hold.
        cycle(0, 0, 0, 0, 4'h0, 0, 0);

        // Random traffic, including addresses whose high bits force wrap-around.
        for (int n = 0; n < 300; n++) begin
            cycle(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
                  $urandom, $urandom);
        end
        cycle(0, 0, 0, 0, 4'h0, 0, 0);

        for (int w = 0; w < DEPTH; w++) begin
            check("img_ram_data", bd_ram_data(w), model[w]);
            check("img_ram", bd_ram(w), model[w]);
        end

        // Reset while reads are in flight: outputs clear at once, no valid appears later.
        i_mem_read = 1'b1;
        d_mem_read = 1'b1;
        i_mem_address_in = 32'h4;
        d_mem_address_in = 32'h4;
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        @(posedge clock);
        #1;
        check_outputs_zero("mid_rst_edge");
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        reset = 1'b1;
        ei_data = '0; ei_addr = '0; ed_data = '0; ed_addr = '0;
        cycle(0, 0, 0, 0, 4'h0, 0, 0);
        cycle(1, 32'h28, 1, 0, 4'h0, 32'h40, 0);
        check("post_rst_d", d_mem_data_out, 32'hDEADBEEF & 32'hFFFFFFFF ^ 32'h0 ? model[16] : model[16]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout got=running exp=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
